// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath.
//   - Next-PC select encodings (PCSrc)
//   - Opcode constants shared with the control FSM
//   - Instruction field bit positions
//   - Default reset PC and a sign-extension helper
package mips_mc_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,   // PC+4 during fetch
        PCSRC_ALUOUT = 2'b01,   // branch target computed in decode
        PCSRC_JUMP   = 2'b10,   // {pc[31:28], instr[25:0], 2'b00}
        PCSRC_RSVD   = 2'b11    // reserved: PC holds
    } pcsrc_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int TARGET_HI = 25;
    localparam int TARGET_LO = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_fetch_regs_if.sv
// Bus between the control FSM / surrounding datapath and mc_fetch_regs.
//   master : FSM controls, ALU result/zero, memory read data, register file reads
//   slave  : the register stage; returns PC/IR/MDR/A/B/ALUOut, memory address,
//            decoded instruction fields, pc_en, instruction count, misalign flag
interface mc_fetch_regs_if #(parameter int WIDTH = 32);

    logic             PCwrite;
    logic             Branch;
    logic             IRwrite;
    logic             IorD;
    logic [1:0]       PCSrc;
    logic             zero;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [5:0]       funct;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] aluout;
    logic             pc_en;
    logic [31:0]      instr_count;
    logic             pc_misalign;

    modport master (
        output PCwrite, Branch, IRwrite, IorD, PCSrc, zero,
               alu_result, mem_rdata, rd1, rd2,
        input  mem_addr, pc, instr, opcode, rs, rt, rd, funct, imm_sext,
               jump_target, mdr, a_reg, b_reg, aluout, pc_en,
               instr_count, pc_misalign
    );

    modport slave (
        input  PCwrite, Branch, IRwrite, IorD, PCSrc, zero,
               alu_result, mem_rdata, rd1, rd2,
        output mem_addr, pc, instr, opcode, rs, rt, rd, funct, imm_sext,
               jump_target, mdr, a_reg, b_reg, aluout, pc_en,
               instr_count, pc_misalign
    );

endinterface

// File: rtl/mc_fetch_regs_dp_en_reg.sv
// dp_en_reg: generic datapath register with synchronous reset value and load
// enable. Tie i_en high for registers that capture every cycle.
//   clk, reset : clock, synchronous active-high reset
//   i_en       : load enable
//   i_d        : data in
//   o_q        : registered data out
module dp_en_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mc_fetch_regs.sv
// mc_fetch_regs: register stage of the multi-cycle MIPS datapath.
// Holds PC, IR, MDR, A, B and ALUOut, selects the unified-memory address,
// computes the next PC and decodes the instruction fields in IR.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mc_fetch_regs_if (controls and data in,
//                architectural registers and decoded fields out)
module mc_fetch_regs
    import mips_mc_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    mc_fetch_regs_if.slave     bus
);

    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] w_ir;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_jump_target;
    logic             w_pc_en;
    logic             w_pc_load;
    logic [31:0]      r_instr_count;
    logic             r_pc_misalign;

    // Branch only loads PC when the ALU comparison succeeded.
    assign w_pc_en       = bus.PCwrite | (bus.Branch & bus.zero);
    assign w_jump_target = {w_pc[31:28], w_ir[TARGET_HI:TARGET_LO], 2'b00};

    // NOTE: every always_comb output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_pc_next = w_pc;
        case (pcsrc_t'(bus.PCSrc))
            PCSRC_ALU:    w_pc_next = bus.alu_result;
            PCSRC_ALUOUT: w_pc_next = bus.aluout;
            PCSRC_JUMP:   w_pc_next = w_jump_target;
            default:      w_pc_next = w_pc;
        endcase
    end

    // The reserved select suppresses the load entirely, so it can neither
    // move PC nor raise the misalign flag.
    assign w_pc_load = w_pc_en && (pcsrc_t'(bus.PCSrc) != PCSRC_RSVD);

    dp_en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .i_en(w_pc_load), .i_d(w_pc_next), .o_q(w_pc)
    );

    dp_en_reg #(.WIDTH(WIDTH)) u_ir (
        .clk(clk), .reset(reset), .i_en(bus.IRwrite), .i_d(bus.mem_rdata), .o_q(w_ir)
    );

    dp_en_reg #(.WIDTH(WIDTH)) u_mdr (
        .clk(clk), .reset(reset), .i_en(1'b1), .i_d(bus.mem_rdata), .o_q(bus.mdr)
    );

    dp_en_reg #(.WIDTH(WIDTH)) u_a (
        .clk(clk), .reset(reset), .i_en(1'b1), .i_d(bus.rd1), .o_q(bus.a_reg)
    );

    dp_en_reg #(.WIDTH(WIDTH)) u_b (
        .clk(clk), .reset(reset), .i_en(1'b1), .i_d(bus.rd2), .o_q(bus.b_reg)
    );

    dp_en_reg #(.WIDTH(WIDTH)) u_aluout (
        .clk(clk), .reset(reset), .i_en(1'b1), .i_d(bus.alu_result), .o_q(bus.aluout)
    );

    // Misalign is sticky until reset; instr_count wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_misalign <= 1'b0;
            r_instr_count <= '0;
        end else begin
            if (w_pc_load && (w_pc_next[1:0] != 2'b00)) begin
                r_pc_misalign <= 1'b1;
            end
            if (bus.IRwrite) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    assign bus.mem_addr    = bus.IorD ? bus.aluout : w_pc;
    assign bus.pc          = w_pc;
    assign bus.instr       = w_ir;
    assign bus.opcode      = w_ir[OPCODE_HI:OPCODE_LO];
    assign bus.rs          = w_ir[RS_HI:RS_LO];
    assign bus.rt          = w_ir[RT_HI:RT_LO];
    assign bus.rd          = w_ir[RD_HI:RD_LO];
    assign bus.funct       = w_ir[FUNCT_HI:FUNCT_LO];
    assign bus.imm_sext    = sign_ext16(w_ir[IMM_HI:IMM_LO]);
    assign bus.jump_target = w_jump_target;
    assign bus.pc_en       = w_pc_en;
    assign bus.instr_count = r_instr_count;
    assign bus.pc_misalign = r_pc_misalign;

endmodule

// File: tb/tb_mc_fetch_regs.sv
// Testbench for mc_fetch_regs: directed scenarios plus a randomized run, all
// checked against a behavioural model of the register stage.
module tb_mc_fetch_regs;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mc_fetch_regs_if #(.WIDTH(32)) bus ();

    mc_fetch_regs #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Behavioural model state.
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout, m_cnt;
    logic        m_mis;

    function automatic logic [31:0] m_jt();
        return (m_pc & 32'hF000_0000) | ({6'b0, m_ir[25:0]} << 2);
    endfunction

    function automatic logic m_pc_en();
        return bus.PCwrite || (bus.Branch && bus.zero);
    endfunction

    // Advance one clock; model consumes the inputs present before the edge.
    task automatic tick();
        logic [31:0] n_pc, n_ir, n_mdr, n_a, n_b, n_alu, n_cnt;
        logic        n_mis;
        logic        loads;
        if (reset) begin
            n_pc = 32'h0; n_ir = 0; n_mdr = 0; n_a = 0; n_b = 0; n_alu = 0;
            n_cnt = 0; n_mis = 1'b0;
        end else begin
            n_pc  = m_pc;
            loads = m_pc_en() && (bus.PCSrc != 2'd3);
            if (loads) begin
                if (bus.PCSrc == 2'd0) n_pc = bus.alu_result;
                else if (bus.PCSrc == 2'd1) n_pc = m_aluout;
                else n_pc = m_jt();
            end
            n_mis = m_mis || (loads && (n_pc % 4 != 0));
            n_ir  = bus.IRwrite ? bus.mem_rdata : m_ir;
            n_cnt = bus.IRwrite ? m_cnt + 1 : m_cnt;
            n_mdr = bus.mem_rdata;
            n_a   = bus.rd1;
            n_b   = bus.rd2;
            n_alu = bus.alu_result;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ir = n_ir; m_mdr = n_mdr; m_a = n_a; m_b = n_b;
        m_aluout = n_alu; m_cnt = n_cnt; m_mis = n_mis;
    endtask

    task automatic idle_inputs();
        bus.PCwrite = 0; bus.Branch = 0; bus.IRwrite = 0; bus.IorD = 0;
        bus.PCSrc = 2'd0; bus.zero = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.PCwrite = 1; bus.IRwrite = 1; bus.PCSrc = 2'd0; bus.Branch = 0;
        bus.IorD = 0; bus.zero = 0;
        bus.alu_result = 32'h0000_0102; bus.mem_rdata = 32'h1234_5678;
        bus.rd1 = 32'h11; bus.rd2 = 32'h22;
        tick();
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
        total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", bus.instr, 32'h0); end
        total++; if (bus.instr_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=%h", bus.instr_count, 32'h0); end
        total++; if (bus.pc_misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", bus.pc_misalign); end
        total++; if ({bus.mdr, bus.a_reg, bus.b_reg, bus.aluout} !== 128'h0) begin bad++; $display("FAIL reset_dregs got=%h %h %h %h exp=0", bus.mdr, bus.a_reg, bus.b_reg, bus.aluout); end
    endtask

    task automatic test_fetch();
        bus.mem_rdata = 32'h8C08_0004; bus.alu_result = 32'h4;
        bus.PCwrite = 1; bus.IRwrite = 1; bus.PCSrc = 2'd0; bus.IorD = 0;
        #1;
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL fetch_addr got=%h exp=%h", bus.mem_addr, 32'h0); end
        tick();
        idle_inputs();
        #1;
        total++; if (bus.pc !== 32'h4) begin bad++; $display("FAIL fetch_pc got=%h exp=%h", bus.pc, 32'h4); end
        total++; if (bus.opcode !== 6'h23) begin bad++; $display("FAIL fetch_opcode got=%h exp=%h", bus.opcode, 6'h23); end
        total++; if (bus.rt !== 5'd8) begin bad++; $display("FAIL fetch_rt got=%0d exp=8", bus.rt); end
        total++; if (bus.imm_sext !== 32'h4) begin bad++; $display("FAIL fetch_imm got=%h exp=%h", bus.imm_sext, 32'h4); end
        total++; if (bus.instr_count !== 32'd1) begin bad++; $display("FAIL fetch_count got=%0d exp=1", bus.instr_count); end
    endtask

    task automatic test_branch();
        bus.alu_result = 32'h40;
        tick();
        bus.alu_result = 32'h0000_0999;
        bus.Branch = 1; bus.zero = 1; bus.PCSrc = 2'd1;
        #1;
        total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL branch_taken_en got=%b exp=1", bus.pc_en); end
        tick();
        total++; if (bus.pc !== 32'h40) begin bad++; $display("FAIL branch_taken_pc got=%h exp=%h", bus.pc, 32'h40); end
        bus.zero = 0; bus.PCSrc = 2'd1; bus.alu_result = 32'h80;
        #1;
        total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL branch_nt_en got=%b exp=0", bus.pc_en); end
        tick();
        total++; if (bus.pc !== 32'h40) begin bad++; $display("FAIL branch_nt_pc got=%h exp=%h", bus.pc, 32'h40); end
        // Both enables together still load PC.
        bus.PCwrite = 1; bus.zero = 1; bus.PCSrc = 2'd0; bus.alu_result = 32'h44;
        #1;
        total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL branch_both_en got=%b exp=1", bus.pc_en); end
        tick();
        total++; if (bus.pc !== 32'h44) begin bad++; $display("FAIL branch_both_pc got=%h exp=%h", bus.pc, 32'h44); end
        idle_inputs();
    endtask

    task automatic test_jump();
        bus.PCwrite = 1; bus.PCSrc = 2'd0; bus.alu_result = 32'h1000_0004;
        bus.IRwrite = 1; bus.mem_rdata = 32'h0800_0010;
        tick();
        bus.IRwrite = 0; bus.PCSrc = 2'd2; bus.alu_result = 32'h0;
        #1;
        total++; if (bus.jump_target !== 32'h1000_0040) begin bad++; $display("FAIL jump_target got=%h exp=%h", bus.jump_target, 32'h1000_0040); end
        tick();
        total++; if (bus.pc !== 32'h1000_0040) begin bad++; $display("FAIL jump_pc got=%h exp=%h", bus.pc, 32'h1000_0040); end
        idle_inputs();
    endtask

    task automatic test_latency();
        bus.alu_result = 32'h20; bus.rd1 = 32'hA5A5_0001; bus.rd2 = 32'h5A5A_0002;
        tick();
        bus.IorD = 1; bus.mem_rdata = 32'hDEAD_BEEF; bus.alu_result = 32'h0;
        #1;
        total++; if (bus.mem_addr !== 32'h20) begin bad++; $display("FAIL lat_addr got=%h exp=%h", bus.mem_addr, 32'h20); end
        total++; if (bus.a_reg !== 32'hA5A5_0001 || bus.b_reg !== 32'h5A5A_0002) begin bad++; $display("FAIL lat_ab got=%h %h exp=%h %h", bus.a_reg, bus.b_reg, 32'hA5A5_0001, 32'h5A5A_0002); end
        tick();
        total++; if (bus.mdr !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lat_mdr got=%h exp=%h", bus.mdr, 32'hDEAD_BEEF); end
        idle_inputs();
    endtask

    task automatic test_corners();
        logic [31:0] held;
        held = m_pc;
        bus.PCwrite = 1; bus.PCSrc = 2'd3; bus.alu_result = 32'h0000_1237;
        tick();
        total++; if (bus.pc !== held) begin bad++; $display("FAIL rsvd_hold got=%h exp=%h", bus.pc, held); end
        total++; if (bus.pc_misalign !== 1'b0) begin bad++; $display("FAIL rsvd_misalign got=%b exp=0", bus.pc_misalign); end
        bus.PCSrc = 2'd0; bus.alu_result = 32'h6;
        tick();
        total++; if (bus.pc !== 32'h6 || bus.pc_misalign !== 1'b1) begin bad++; $display("FAIL misalign_set got=%h/%b exp=%h/1", bus.pc, bus.pc_misalign, 32'h6); end
        bus.alu_result = 32'h8;
        tick();
        idle_inputs();
        tick(); tick();
        total++; if (bus.pc_misalign !== 1'b1) begin bad++; $display("FAIL misalign_sticky got=%b exp=1", bus.pc_misalign); end
        // Preload the counter near its limit, then one IR load wraps it.
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        m_cnt = 32'hFFFF_FFFF;
        bus.IRwrite = 1; bus.mem_rdata = 32'h0000_0020;
        tick();
        total++; if (bus.instr_count !== 32'h0) begin bad++; $display("FAIL count_wrap got=%h exp=%h", bus.instr_count, 32'h0); end
        // Reset mid-instruction with enables active clears everything.
        reset = 1; bus.PCwrite = 1; bus.alu_result = 32'h3;
        tick();
        reset = 0; idle_inputs();
        #1;
        total++; if (bus.pc !== 32'h0 || bus.pc_misalign !== 1'b0 || bus.instr_count !== 32'h0) begin bad++; $display("FAIL midreset got=%h/%b/%h exp=0/0/0", bus.pc, bus.pc_misalign, bus.instr_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 49) == 0);
            bus.PCwrite    = $urandom_range(0, 2) == 0;
            bus.Branch     = $urandom_range(0, 3) == 0;
            bus.zero       = 1'($urandom);
            bus.IRwrite    = $urandom_range(0, 2) == 0;
            bus.IorD       = 1'($urandom);
            bus.PCSrc      = 2'($urandom);
            bus.alu_result = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            bus.mem_rdata  = $urandom;
            bus.rd1        = $urandom;
            bus.rd2        = $urandom;
            #1;
            total++; if (bus.pc_en !== m_pc_en()) begin bad++; $display("FAIL rnd_pc_en i=%0d got=%b exp=%b", i, bus.pc_en, m_pc_en()); end
            total++; if (bus.mem_addr !== (bus.IorD ? m_aluout : m_pc)) begin bad++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, bus.mem_addr, bus.IorD ? m_aluout : m_pc); end
            tick();
            total++; if (bus.pc !== m_pc) begin bad++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, bus.pc, m_pc); end
            total++; if (bus.instr !== m_ir || bus.instr_count !== m_cnt) begin bad++; $display("FAIL rnd_ir i=%0d got=%h/%0d exp=%h/%0d", i, bus.instr, bus.instr_count, m_ir, m_cnt); end
            total++; if ({bus.mdr, bus.a_reg, bus.b_reg, bus.aluout} !== {m_mdr, m_a, m_b, m_aluout}) begin bad++; $display("FAIL rnd_dregs i=%0d got=%h %h %h %h exp=%h %h %h %h", i, bus.mdr, bus.a_reg, bus.b_reg, bus.aluout, m_mdr, m_a, m_b, m_aluout); end
            total++; if (bus.pc_misalign !== m_mis) begin bad++; $display("FAIL rnd_misalign i=%0d got=%b exp=%b", i, bus.pc_misalign, m_mis); end
            total++; if (bus.jump_target !== m_jt() || bus.imm_sext !== 32'($signed(m_ir[15:0]))) begin bad++; $display("FAIL rnd_decode i=%0d got=%h/%h exp=%h/%h", i, bus.jump_target, bus.imm_sext, m_jt(), 32'($signed(m_ir[15:0]))); end
            total++; if ({bus.opcode, bus.rs, bus.rt, bus.rd, bus.funct} !== {m_ir[31:11], m_ir[5:0]}) begin bad++; $display("FAIL rnd_fields i=%0d got=%h exp=%h", i, {bus.opcode, bus.rs, bus.rt, bus.rd, bus.funct}, {m_ir[31:11], m_ir[5:0]}); end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        m_pc = 0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0; m_cnt = 0; m_mis = 0;
        idle_inputs();
        bus.alu_result = 0; bus.mem_rdata = 0; bus.rd1 = 0; bus.rd2 = 0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_latency();
        test_corners();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
